// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04 responder emulator: qualifies a trig pulse, waits a burst delay, then
// drives echo high for a time proportional to the latched distance.
module ultrasonic_echo_emulator #(
    parameter int unsigned clk_frequency  = 27_000_000,
    parameter int unsigned distance_width = 16,
    parameter int unsigned trig_min_us    = 10,
    parameter int unsigned burst_delay_us = 200,
    parameter int unsigned us_per_unit    = 58,
    parameter int unsigned timeout_us     = 38000,
    parameter int unsigned holdoff_us     = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      trig,
    input  logic                      enable,
    input  logic [distance_width-1:0] distance,
    output logic                      echo,
    output logic                      busy,
    output logic                      trig_reject,
    output logic [7:0]                ping_count
);

    localparam int unsigned DW           = distance_width;
    localparam int unsigned CPU          = clk_frequency / 1_000_000;
    localparam int unsigned TRIG_MIN_CYC = trig_min_us * CPU;
    localparam int unsigned BURST_CYC    = burst_delay_us * CPU;
    localparam int unsigned UNIT_CYC     = us_per_unit * CPU;
    localparam int unsigned TIMEOUT_CYC  = timeout_us * CPU;
    localparam int unsigned HOLD_CYC     = holdoff_us * CPU;

    // One shared counter serves every timed state, so size it for the largest terminal.
    localparam int unsigned MAX_A   = (TRIG_MIN_CYC > BURST_CYC) ? TRIG_MIN_CYC : BURST_CYC;
    localparam int unsigned MAX_B   = (UNIT_CYC > TIMEOUT_CYC) ? UNIT_CYC : TIMEOUT_CYC;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_MAX = (MAX_C > HOLD_CYC) ? MAX_C : HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TRIG_SAT_C    = CNT_W'(TRIG_MIN_CYC);
    localparam logic [CNT_W-1:0] TRIG_ACCEPT_C = CNT_W'(TRIG_MIN_CYC - 1);
    localparam logic [CNT_W-1:0] BURST_C       = CNT_W'(BURST_CYC);
    localparam logic [CNT_W-1:0] UNIT_LAST_C   = CNT_W'(UNIT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST_C = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST_C   = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG_HIGH = 3'd1,
        DELAY     = 3'd2,
        ECHO      = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, ts_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    dist_cnt_q, dist_cnt_d;
    logic [DW-1:0]    dist_lat_q, dist_lat_d;
    logic             oor_q, oor_d;
    logic             echo_q, echo_d;
    logic             busy_q, busy_d;
    logic             reject_q, reject_d;
    logic [7:0]       ping_q, ping_d;

    logic             ts_rise_c, ts_fall_c;
    logic [CNT_W-1:0] unit_last_c;
    logic             dist_last_c;

    assign ts_rise_c   = sync2_q & ~ts_prev_q;
    assign ts_fall_c   = ~sync2_q & ts_prev_q;
    // Out-of-range pings run one long "unit" of timeout length.
    assign unit_last_c = oor_q ? TIMEOUT_LAST_C : UNIT_LAST_C;
    assign dist_last_c = oor_q | (dist_cnt_q == (dist_lat_q - DW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            ts_prev_q  <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            dist_cnt_q <= '0;
            dist_lat_q <= '0;
            oor_q      <= 1'b0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            reject_q   <= 1'b0;
            ping_q     <= '0;
        end else begin
            sync1_q    <= trig;
            sync2_q    <= sync1_q;
            ts_prev_q  <= sync2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dist_cnt_q <= dist_cnt_d;
            dist_lat_q <= dist_lat_d;
            oor_q      <= oor_d;
            echo_q     <= echo_d;
            busy_q     <= busy_d;
            reject_q   <= reject_d;
            ping_q     <= ping_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dist_cnt_d = dist_cnt_q;
        dist_lat_d = dist_lat_q;
        oor_d      = oor_q;
        echo_d     = 1'b0;
        reject_d   = 1'b0;
        ping_d     = ping_q;

        case (state_q)
            IDLE: begin
                if (enable && ts_rise_c) begin
                    state_d = TRIG_HIGH;
                    cnt_d   = '0;
                end
            end
            TRIG_HIGH: begin
                // The rise cycle itself is not counted, so accept at one less.
                if (ts_fall_c) begin
                    if (cnt_q >= TRIG_ACCEPT_C) begin
                        state_d    = DELAY;
                        cnt_d      = '0;
                        dist_lat_d = distance;
                        oor_d      = (distance == '0);
                    end else begin
                        state_d  = IDLE;
                        reject_d = 1'b1;
                    end
                end else if (cnt_q != TRIG_SAT_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DELAY: begin
                if (cnt_q == BURST_C) begin
                    state_d    = ECHO;
                    echo_d     = 1'b1;
                    cnt_d      = '0;
                    dist_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ECHO: begin
                echo_d = 1'b1;
                if (cnt_q == unit_last_c) begin
                    cnt_d = '0;
                    if (dist_last_c) begin
                        echo_d  = 1'b0;
                        ping_d  = ping_q + 8'd1;
                        state_d = HOLDOFF;
                    end else begin
                        dist_cnt_d = dist_cnt_q + DW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST_C) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable aborts any ping in progress without counting it.
        if (!enable) begin
            state_d  = IDLE;
            echo_d   = 1'b0;
            reject_d = 1'b0;
            ping_d   = ping_q;
        end

        busy_d = (state_d != IDLE);
    end

    assign echo        = echo_q;
    assign busy        = busy_q;
    assign trig_reject = reject_q;
    assign ping_count  = ping_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator at 1 cycle = 1 us; burst delay and
// timeout are shortened (20 us, 3800 us) so the 256-ping wrap run stays short.
module tb_ultrasonic_echo_emulator;

    localparam int unsigned BURST = 20;
    localparam int unsigned UNIT  = 58;
    localparam int unsigned TOUT  = 3800;
    localparam int unsigned HOLD  = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig;
    logic        enable;
    logic [15:0] distance;
    logic        echo;
    logic        busy;
    logic        trig_reject;
    logic [7:0]  ping_count;

    int total = 0;
    int bad   = 0;

    ultrasonic_echo_emulator #(
        .clk_frequency (1_000_000),
        .distance_width(16),
        .trig_min_us   (10),
        .burst_delay_us(BURST),
        .us_per_unit   (UNIT),
        .timeout_us    (TOUT),
        .holdoff_us    (HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig),
        .enable     (enable),
        .distance   (distance),
        .echo       (echo),
        .busy       (busy),
        .trig_reject(trig_reject),
        .ping_count (ping_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pin high for exactly w sampling edges; returns just after the edge before the first low sample.
    task automatic pulse_trig(input int w);
        @(posedge clk);
        #1 trig = 1'b1;
        repeat (w) @(posedge clk);
        #1 trig = 1'b0;
    endtask

    // k = index of the edge (0 = first edge sampling trig low) after which echo is high.
    task automatic measure_rise(output int k);
        k = 0;
        forever begin
            tick();
            if (echo) return;
            k++;
            if (k > 200) begin
                k = -1;
                return;
            end
        end
    endtask

    task automatic measure_width(output int w);
        w = 0;
        forever begin
            tick();
            w++;
            if (!echo) return;
            if (w > 5000) begin
                w = -1;
                return;
            end
        end
    endtask

    task automatic measure_holdoff(output int h);
        h = 0;
        forever begin
            tick();
            h++;
            if (!busy) return;
            if (h > 500) begin
                h = -1;
                return;
            end
        end
    endtask

    initial begin
        int k, w, h, rej_cnt, rej_at, echo_hi, wrap_errs;

        rst_n    = 1'b0;
        trig     = 1'b0;
        enable   = 1'b1;
        distance = 16'd5;
        #12;
        check("reset_echo", int'(echo), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_reject", int'(trig_reject), 0);
        check("reset_ping", int'(ping_count), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Nominal: distance 5, 12-cycle trig, with busy rise timing checked.
        @(posedge clk);
        #1 trig = 1'b1;
        tick();
        tick();
        check("busy_before_rise", int'(busy), 0);
        tick();
        check("busy_after_rise", int'(busy), 1);
        repeat (9) @(posedge clk);
        #1 trig = 1'b0;
        measure_rise(k);
        check("nom_rise_delay", k, BURST + 3);
        check("nom_busy_in_echo", int'(busy), 1);
        measure_width(w);
        check("nom_width", w, 5 * UNIT);
        check("nom_ping", int'(ping_count), 1);
        measure_holdoff(h);
        check("nom_holdoff", h, HOLD);

        // Runt 9-cycle trig is rejected with a single pulse.
        repeat (3) tick();
        pulse_trig(9);
        rej_cnt = 0;
        rej_at  = -1;
        echo_hi = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (trig_reject) begin
                rej_cnt++;
                if (rej_at < 0) rej_at = i;
            end
            if (echo) echo_hi++;
        end
        check("runt_reject_cycles", rej_cnt, 1);
        check("runt_reject_edge", rej_at, 2);
        check("runt_echo_cycles", echo_hi, 0);
        check("runt_ping", int'(ping_count), 1);
        check("runt_busy", int'(busy), 0);

        // Minimum-width 10-cycle trig is accepted.
        pulse_trig(10);
        measure_rise(k);
        check("min_rise_delay", k, BURST + 3);
        measure_width(w);
        check("min_width", w, 5 * UNIT);
        check("min_ping", int'(ping_count), 2);
        measure_holdoff(h);

        // Out of range: distance 0 gives the timeout width.
        distance = 16'd0;
        repeat (2) tick();
        pulse_trig(12);
        measure_rise(k);
        check("oor_rise_delay", k, BURST + 3);
        measure_width(w);
        check("oor_width", w, TOUT);
        check("oor_ping", int'(ping_count), 3);
        measure_holdoff(h);

        // Latched distance survives a change in DELAY; trig during ECHO is ignored.
        distance = 16'd5;
        repeat (2) tick();
        pulse_trig(12);
        repeat (6) tick();
        distance = 16'd9;
        measure_rise(k);
        check("latch_rise_delay", k, BURST + 3 - 6);
        repeat (20) @(posedge clk);
        pulse_trig(12);
        measure_width(w);
        check("latch_width", 20 + 13 + w, 5 * UNIT);
        check("latch_ping", int'(ping_count), 4);
        // Trig held high across re-arm must not start a new ping.
        tick();
        trig = 1'b1;
        echo_hi = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (echo) echo_hi++;
        end
        check("rearm_no_echo", echo_hi, 0);
        check("rearm_busy", int'(busy), 0);
        check("rearm_ping", int'(ping_count), 4);
        trig = 1'b0;
        repeat (5) tick();

        // Abort by dropping enable at echo cycle 100.
        distance = 16'd5;
        pulse_trig(12);
        measure_rise(k);
        check("abort_rise_delay", k, BURST + 3);
        repeat (99) @(posedge clk);
        #1;
        check("abort_echo_before", int'(echo), 1);
        enable = 1'b0;
        tick();
        check("abort_echo_after", int'(echo), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ping", int'(ping_count), 4);
        enable = 1'b1;
        repeat (5) tick();

        // Asynchronous reset mid-DELAY clears everything at once.
        pulse_trig(12);
        repeat (5) tick();
        check("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_echo", int'(echo), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_reject", int'(trig_reject), 0);
        check("arst_ping", int'(ping_count), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        echo_hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (echo) echo_hi++;
        end
        check("post_reset_no_echo", echo_hi, 0);

        // Wrap: 256 back-to-back distance-1 pings.
        distance  = 16'd1;
        wrap_errs = 0;
        for (int i = 0; i < 256; i++) begin
            pulse_trig(10);
            measure_rise(k);
            measure_width(w);
            if (w != UNIT) wrap_errs++;
            measure_holdoff(h);
            if (i == 254) check("wrap_ping_255", int'(ping_count), 255);
        end
        check("wrap_width_errs", wrap_errs, 0);
        check("wrap_ping_0", int'(ping_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
